// File: rtl/arb_rr_n.sv
// arb_rr_n: N-channel valid/ready arbiter with a single registered output stage.
// Channels compete for one output register; the winner is chosen either by
// fixed priority (lowest index wins) or by round-robin starting at a rotating
// pointer. Losing channels see ready low and must hold their request.
module arb_rr_n #(
  parameter int p_st_bits = 32,
  parameter int p_num_ch  = 8,
  parameter int p_mode    = 0,
  parameter int p_ch_bits = (p_num_ch > 1) ? $clog2(p_num_ch) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [p_num_ch*p_st_bits-1:0] iSnkData,
  input  logic [p_num_ch-1:0]           iSnkValid,
  output logic [p_num_ch-1:0]           oSnkReady,
  output logic [p_st_bits-1:0]          oSrcData,
  output logic                          oSrcValid,
  output logic [p_ch_bits-1:0]          oSrcChan,
  input  logic                          iSrcReady
);

  logic [p_st_bits-1:0] data_q;
  logic                 valid_q;
  logic [p_ch_bits-1:0] chan_q;
  logic [p_ch_bits-1:0] ptr;
  logic [p_ch_bits-1:0] win;
  logic [p_st_bits-1:0] win_data;
  logic                 any_valid;
  logic                 ld;

  // The output register may accept a word when empty or being drained now.
  assign ld = ~valid_q | iSrcReady;

  // Scan channels starting at the pointer (always 0 in fixed-priority mode),
  // wrapping around, and take the first valid one as the winner.
  always_comb begin
    int idx;
    win       = '0;
    win_data  = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = 0; k < p_num_ch; k++) begin
      idx = int'(ptr) + k;
      if (idx >= p_num_ch) idx = idx - p_num_ch;
      if (!any_valid && iSnkValid[idx]) begin
        any_valid = 1'b1;
        win       = p_ch_bits'(idx);
        win_data  = iSnkData[idx*p_st_bits +: p_st_bits];
      end
    end
  end

  // Grant exactly the winner, only when the output stage can load and
  // never while reset is held.
  always_comb begin
    oSnkReady = '0;
    if (ld && any_valid && rst) oSnkReady[win] = 1'b1;
  end

  // Output stage: load the winner, empty out when nothing is offered,
  // or hold everything while the downstream stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      chan_q  <= '0;
    end else if (ld) begin
      if (any_valid) begin
        data_q  <= win_data;
        chan_q  <= win;
        valid_q <= 1'b1;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  generate
    if (p_mode == 1) begin : g_rr
      logic [p_ch_bits-1:0] ptr_next;
      logic [p_ch_bits-1:0] ptr_q;

      assign ptr_next = (win == p_ch_bits'(p_num_ch - 1)) ? '0 : win + 1'b1;
      assign ptr      = ptr_q;

      // The pointer moves just past the winner on every sink transfer so the
      // channel that was just served drops to lowest priority.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          ptr_q <= '0;
        end else if (ld && any_valid) begin
          ptr_q <= ptr_next;
        end
      end
    end else begin : g_fp
      assign ptr = '0;
    end
  endgenerate

  assign oSrcData  = data_q;
  assign oSrcValid = valid_q;
  assign oSrcChan  = chan_q;

endmodule
